// File: rtl/siteswap_loader.sv
// siteswap_loader
//   Collects a siteswap pattern one throw digit at a time, validates it and loads it into the
//   trajectory generator. Validation checks that the pattern is non-empty, that its digit sum
//   divides evenly by its length (the quotient is the ball count, 1..7) and that no two throws
//   land on the same beat. A good pattern restarts the generator with a one-cycle gen_rst_out
//   pulse and is then presented, unrolled to seven entries, with pattern_valid_out held high.
//
// Ports
//   clk_in             system clock
//   rst_in             synchronous active-high reset
//   digit_in           throw value to append (0..7)
//   digit_valid_in     1-cycle strobe: append digit_in
//   commit_in          1-cycle strobe: validate and load the collected digits
//   clear_in           1-cycle strobe: discard collected digits and any error / abort a check
//   pattern_out        unrolled pattern, pattern_out[i] = p[i mod L]
//   pattern_len_out    L of the loaded pattern
//   num_balls_out      digit sum / L of the loaded pattern
//   pattern_valid_out  level, a validated pattern is loaded and presented
//   gen_rst_out        1-cycle restart pulse to the generator
//   error_out          0 none, 1 empty, 2 bad average, 3 landing collision
//   busy_out           high while summing, dividing, checking or loading
module siteswap_loader #(
  parameter int unsigned MAX_LEN = 7,
  parameter int unsigned DIGIT_W = 3
) (
  input  logic                              clk_in,
  input  logic                              rst_in,
  input  logic [DIGIT_W-1:0]                digit_in,
  input  logic                              digit_valid_in,
  input  logic                              commit_in,
  input  logic                              clear_in,
  output logic [MAX_LEN-1:0][DIGIT_W-1:0]   pattern_out,
  output logic [2:0]                        pattern_len_out,
  output logic [2:0]                        num_balls_out,
  output logic                              pattern_valid_out,
  output logic                              gen_rst_out,
  output logic [1:0]                        error_out,
  output logic                              busy_out
);

  localparam logic [1:0] ErrNone    = 2'd0;
  localparam logic [1:0] ErrEmpty   = 2'd1;
  localparam logic [1:0] ErrAverage = 2'd2;
  localparam logic [1:0] ErrCollide = 2'd3;

  typedef enum logic [2:0] {
    StCollect = 3'd0,
    StSum     = 3'd1,
    StDiv     = 3'd2,
    StCheck   = 3'd3,
    StLoad    = 3'd4,
    StValid   = 3'd5,
    StErr     = 3'd6
  } state_e;

  state_e                   state_q;
  logic [DIGIT_W-1:0]       digits_q [MAX_LEN];
  logic [2:0]               len_q;
  logic [2:0]               idx_q;
  logic [5:0]               sum_q;
  logic [5:0]               rem_q;
  logic [3:0]               quo_q;
  logic [MAX_LEN-1:0]       mask_q;

  logic [5:0]               sum_next;
  logic                     last_idx;
  logic [3:0]               land_sum;
  logic [3:0]               land_full;
  logic [2:0]               land;
  logic [MAX_LEN-1:0][DIGIT_W-1:0] unrolled;

  assign sum_next = sum_q + 6'(digits_q[idx_q]);
  assign last_idx = (idx_q == len_q - 3'd1);

  // Landing beat of throw i, taken modulo the pattern length (operand never exceeds 13).
  assign land_sum  = 4'(idx_q) + 4'(digits_q[idx_q]);
  assign land_full = (len_q == 3'd0) ? 4'd0 : (land_sum % {1'b0, len_q});
  assign land      = land_full[2:0];

  // Pattern repeated to fill every bus entry.
  always_comb begin
    unrolled = '0;
    for (int i = 0; i < int'(MAX_LEN); i++) begin
      if (len_q != 3'd0) begin
        unrolled[i] = digits_q[3'(i % int'(len_q))];
      end
    end
  end

  assign busy_out = (state_q == StSum) || (state_q == StDiv) ||
                    (state_q == StCheck) || (state_q == StLoad);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q           <= StCollect;
      len_q             <= 3'd0;
      idx_q             <= 3'd0;
      sum_q             <= 6'd0;
      rem_q             <= 6'd0;
      quo_q             <= 4'd0;
      mask_q            <= '0;
      for (int i = 0; i < int'(MAX_LEN); i++) begin
        digits_q[i] <= '0;
      end
      pattern_out       <= '0;
      pattern_len_out   <= 3'd0;
      num_balls_out     <= 3'd0;
      pattern_valid_out <= 1'b0;
      gen_rst_out       <= 1'b0;
      error_out         <= ErrNone;
    end else begin
      gen_rst_out <= 1'b0;
      case (state_q)
        StCollect: begin
          // clear beats commit, commit beats a same-cycle digit
          if (clear_in) begin
            len_q     <= 3'd0;
            error_out <= ErrNone;
          end else if (commit_in) begin
            if (len_q == 3'd0) begin
              state_q   <= StErr;
              error_out <= ErrEmpty;
            end else begin
              state_q           <= StSum;
              error_out         <= ErrNone;
              pattern_valid_out <= 1'b0;
              idx_q             <= 3'd0;
              sum_q             <= 6'd0;
            end
          end else if (digit_valid_in && (len_q < 3'(MAX_LEN))) begin
            digits_q[len_q] <= digit_in;
            len_q           <= len_q + 3'd1;
          end
        end

        StSum: begin
          if (clear_in) begin
            state_q <= StCollect;
            len_q   <= 3'd0;
          end else begin
            sum_q <= sum_next;
            idx_q <= idx_q + 3'd1;
            if (last_idx) begin
              state_q <= StDiv;
              rem_q   <= sum_next;
              quo_q   <= 4'd0;
            end
          end
        end

        StDiv: begin
          // Repeated subtraction: one step of sum / L per cycle.
          if (clear_in) begin
            state_q <= StCollect;
            len_q   <= 3'd0;
          end else if (rem_q >= {3'b000, len_q}) begin
            rem_q <= rem_q - {3'b000, len_q};
            quo_q <= quo_q + 4'd1;
          end else if ((rem_q == 6'd0) && (quo_q != 4'd0) && (quo_q <= 4'd7)) begin
            state_q <= StCheck;
            idx_q   <= 3'd0;
            mask_q  <= '0;
          end else begin
            state_q   <= StErr;
            error_out <= ErrAverage;
          end
        end

        StCheck: begin
          if (clear_in) begin
            state_q <= StCollect;
            len_q   <= 3'd0;
          end else if (mask_q[land]) begin
            state_q   <= StErr;
            error_out <= ErrCollide;
          end else begin
            mask_q[land] <= 1'b1;
            idx_q        <= idx_q + 3'd1;
            if (last_idx) begin
              state_q <= StLoad;
            end
          end
        end

        StLoad: begin
          if (clear_in) begin
            state_q <= StCollect;
            len_q   <= 3'd0;
          end else begin
            state_q         <= StValid;
            gen_rst_out     <= 1'b1;
            pattern_out     <= unrolled;
            pattern_len_out <= len_q;
            num_balls_out   <= quo_q[2:0];
          end
        end

        StValid: begin
          // Loaded pattern stays presented until the user starts over.
          if (clear_in) begin
            state_q           <= StCollect;
            len_q             <= 3'd0;
            pattern_valid_out <= 1'b0;
          end else if (digit_valid_in) begin
            state_q           <= StCollect;
            digits_q[0]       <= digit_in;
            len_q             <= 3'd1;
            pattern_valid_out <= 1'b0;
          end else begin
            pattern_valid_out <= 1'b1;
          end
        end

        StErr: begin
          // Error code is held until the user acts; a commit retries the held digits.
          if (clear_in) begin
            state_q   <= StCollect;
            len_q     <= 3'd0;
            error_out <= ErrNone;
          end else if (commit_in) begin
            if (len_q == 3'd0) begin
              error_out <= ErrEmpty;
            end else begin
              state_q   <= StSum;
              error_out <= ErrNone;
              idx_q     <= 3'd0;
              sum_q     <= 6'd0;
            end
          end else if (digit_valid_in) begin
            state_q     <= StCollect;
            digits_q[0] <= digit_in;
            len_q       <= 3'd1;
            error_out   <= ErrNone;
          end
        end

        default: begin
          state_q <= StCollect;
        end
      endcase
    end
  end

endmodule
